// File: rtl/control_network_msg_router.sv
// AXIS control-packet router: the head-beat msg type selects one of NUM_OUT ports through ROUTE_MAP.
// Optional macro CTRL_ROUTER_TDEST_CHECK_EN also drops head beats whose tdest differs from i_local_id.

package control_network_msg_router_pkg;

    localparam int MAX_MAP_BITS = 2048;

    // Byte t of the map holds {valid, 3'b0, port}; by default every type is valid and port = t % num_out.
    function automatic logic [MAX_MAP_BITS-1:0] default_route_map(input int types, input int num_out);
        logic [MAX_MAP_BITS-1:0] map;
        map = '0;
        for (int t = 0; t < types; t++) begin
            map[t*8 +: 8] = {4'h8, 4'(t % num_out)};
        end
        return map;
    endfunction

endpackage

module control_network_msg_router #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_TID_WIDTH   = 8,
    parameter int AXIS_TDEST_WIDTH = 8,
    parameter int AXIS_TUSER_WIDTH = 32,
    parameter int NUM_OUT          = 4,
    parameter int MSG_TYPE_WIDTH   = 4,
    parameter logic [(2**MSG_TYPE_WIDTH)*8-1:0] ROUTE_MAP =
        ((2**MSG_TYPE_WIDTH)*8)'(control_network_msg_router_pkg::default_route_map(2**MSG_TYPE_WIDTH, NUM_OUT))
) (
    input  logic                           i_clk,
    input  logic                           i_ap_rst,

    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]     s_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [AXIS_TID_WIDTH-1:0]      s_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]    s_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0]    s_tuser,
    input  logic                           s_tlast,

    output logic [NUM_OUT-1:0]             m_tvalid,
    input  logic [NUM_OUT-1:0]             m_tready,
    output logic [AXIS_DATA_WIDTH-1:0]     m_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]   m_tkeep,
    output logic [AXIS_TID_WIDTH-1:0]      m_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]    m_tdest,
    output logic [AXIS_TUSER_WIDTH-1:0]    m_tuser,
    output logic                           m_tlast,

    input  logic [AXIS_TDEST_WIDTH-1:0]    i_local_id,
    output logic [15:0]                    o_drop_count
);

    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int PORT_W = $clog2(NUM_OUT);

    typedef enum logic [1:0] {
        ST_HEAD,
        ST_ROUTE,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0]  data;
        logic [KEEP_W-1:0]           keep;
        logic [AXIS_TID_WIDTH-1:0]   id;
        logic [AXIS_TDEST_WIDTH-1:0] dest;
        logic [AXIS_TUSER_WIDTH-1:0] user;
        logic                        last;
    } beat_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic                s_tready_q;
    logic [15:0]         drop_count_q, drop_count_d;

    logic                out_valid_q, out_valid_d;
    beat_t               out_beat_q, out_beat_d;
    logic [PORT_W-1:0]   out_port_q, out_port_d;

    beat_t               skid_beat_q [2];
    beat_t               skid_beat_d [2];
    logic [PORT_W-1:0]   skid_port_q [2];
    logic [PORT_W-1:0]   skid_port_d [2];
    logic [1:0]          count_q, count_d;

    logic [MSG_TYPE_WIDTH-1:0] head_type;
    logic                      entry_valid;
    logic [3:0]                entry_port;
    logic                      map_hit;
    logic                      head_ok;
    logic [PORT_W-1:0]         head_port;
    beat_t                     in_beat;

    logic                accept;
    logic                push;
    logic [PORT_W-1:0]   push_port;
    logic                drop_inc;
    logic                out_pop;
    logic                out_free;

    // Route lookup is done on whatever beat is presented; it only matters in HEAD.
    assign head_type   = s_tdata[MSG_TYPE_WIDTH-1:0];
    assign entry_valid = ROUTE_MAP[{head_type, 3'd7}];
    assign entry_port  = ROUTE_MAP[{head_type, 3'd0} +: 4];
    assign head_port   = entry_port[PORT_W-1:0];
    assign map_hit     = entry_valid && ({1'b0, entry_port} < 5'(NUM_OUT));

`ifdef CTRL_ROUTER_TDEST_CHECK_EN
    assign head_ok = map_hit && (s_tdest == i_local_id);
`else
    logic unused_local_id;
    assign unused_local_id = ^i_local_id;
    assign head_ok = map_hit;
`endif

    assign in_beat = '{data: s_tdata, keep: s_tkeep, id: s_tid, dest: s_tdest, user: s_tuser, last: s_tlast};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            state_q <= ST_HEAD;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

    // Next-state logic.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        case (state_q)
            ST_HEAD: begin
                if (accept) begin
                    if (head_ok) begin
                        port_d  = head_port;
                        state_d = s_tlast ? ST_HEAD : ST_ROUTE;
                    end else begin
                        state_d = s_tlast ? ST_HEAD : ST_DROP;
                    end
                end
            end
            ST_ROUTE, ST_DROP: begin
                if (accept && s_tlast) begin
                    state_d = ST_HEAD;
                end
            end
            default: state_d = ST_HEAD;
        endcase
    end

    // FSM outputs: input handshake, queue push and drop accounting.
    always_comb begin
        s_tready  = 1'b0;
        push      = 1'b0;
        push_port = port_q;
        drop_inc  = 1'b0;
        if (!i_ap_rst) begin
            s_tready = (state_q == ST_DROP) || s_tready_q;
        end
        accept = s_tvalid && s_tready;
        case (state_q)
            ST_HEAD: begin
                push      = accept && head_ok;
                push_port = head_port;
                drop_inc  = accept && !head_ok;
            end
            ST_ROUTE: push = accept;
            default: ;
        endcase
    end

    assign drop_count_d = (drop_inc && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;

    assign out_pop  = out_valid_q && m_tready[out_port_q];
    assign out_free = !out_valid_q || out_pop;

    // Output register refills from the skid head first, so beats never overtake one another.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        out_port_d  = out_port_q;
        skid_beat_d = skid_beat_q;
        skid_port_d = skid_port_q;
        count_d     = count_q;

        if (out_free) begin
            if (count_q != 2'd0) begin
                out_valid_d    = 1'b1;
                out_beat_d     = skid_beat_q[0];
                out_port_d     = skid_port_q[0];
                skid_beat_d[0] = skid_beat_q[1];
                skid_port_d[0] = skid_port_q[1];
                count_d        = count_q - 2'd1;
            end else if (push) begin
                out_valid_d = 1'b1;
                out_beat_d  = in_beat;
                out_port_d  = push_port;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (push && !(out_free && (count_q == 2'd0))) begin
            skid_beat_d[count_d[0]] = in_beat;
            skid_port_d[count_d[0]] = push_port;
            count_d                 = count_d + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            s_tready_q   <= 1'b0;
            drop_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            out_port_q   <= '0;
            count_q      <= '0;
        end else begin
            // Ready is registered: a pop in a full cycle frees space only for the next cycle.
            s_tready_q   <= (count_d != 2'd2);
            drop_count_q <= drop_count_d;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            out_port_q   <= out_port_d;
            count_q      <= count_d;
        end
    end

    // NOTE: skid storage is not reset; count_q alone says which entries hold live beats.
    always_ff @(posedge i_clk) begin
        skid_beat_q <= skid_beat_d;
        skid_port_q <= skid_port_d;
    end

    always_comb begin
        m_tvalid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            m_tvalid[i] = out_valid_q && (out_port_q == PORT_W'(i));
        end
    end

    assign m_tdata      = out_beat_q.data;
    assign m_tkeep      = out_beat_q.keep;
    assign m_tid        = out_beat_q.id;
    assign m_tdest      = out_beat_q.dest;
    assign m_tuser      = out_beat_q.user;
    assign m_tlast      = out_beat_q.last;
    assign o_drop_count = drop_count_q;

endmodule
